// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM encoding and
// settle counter width.
package tt_sweep_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/tt_sweep_checker_settle_timer.sv
// Settle timer: counts WAIT cycles up from zero and flags the last one
// (count == SETTLE-1). load clears, en advances.
module tt_sweep_checker_settle_timer
  import tt_sweep_checker_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep of all 2^N input vectors into two DUT implementations,
// comparing their outputs after SETTLE cycles and recording mismatches.
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] vec,
  input  logic         res_a,
  input  logic         res_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail
);

  localparam logic [N-1:0] LAST_VEC = '1;

  state_t state, state_next;
  logic   clear, check, advance, timer_load, timer_en, timer_term;
  logic   mismatch;

  // Case inequality so an unknown DUT output is reported as a mismatch.
  assign mismatch = (res_a !== res_b);

  tt_sweep_checker_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .term  (timer_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    check      = 1'b0;
    advance    = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear      = 1'b1;
          timer_load = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_en = 1'b1;
        if (timer_term) state_next = S_CHECK;
      end
      S_CHECK: begin
        check = 1'b1;
        // Terminal vector is detected explicitly so vec never wraps in a sweep.
        if (vec == LAST_VEC) begin
          state_next = S_DONE;
        end else begin
          advance    = 1'b1;
          timer_load = 1'b1;
          state_next = S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (clear) begin
      vec        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (check) begin
      if (mismatch) begin
        err_count <= err_count + (N+1)'(1);
        if (!fail_valid) begin
          first_fail <= vec;
          fail_valid <= 1'b1;
        end
      end
      if (advance) vec <= vec + N'(1);
    end
  end

  assign busy = (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: N=2/SETTLE=1 and N=3/SETTLE=3 instances driven
// from a table of sweeps, with vec sequences checked through an expected queue.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start2, start3;
  logic [1:0] vec2;
  logic [2:0] vec3;
  logic       res_a2, res_b2, res_a3, res_b3;
  logic       busy2, done2, pass2, fv2, busy3, done3, pass3, fv3;
  logic [2:0] err2;
  logic [3:0] err3;
  logic [1:0] ff2;
  logic [2:0] ff3;
  int         mode;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tt_sweep_checker #(.N(2), .SETTLE(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .vec(vec2),
    .res_a(res_a2), .res_b(res_b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
  );

  tt_sweep_checker #(.N(3), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .vec(vec3),
    .res_a(res_a3), .res_b(res_b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3), .first_fail(ff3)
  );

  // DUT pair models: A is a NAND; B is a NAND with a mode-selected fault.
  always_comb begin
    res_a2 = ~&vec2;
    case (mode)
      1:       res_b2 = (vec2 == 2'b10) ? 1'b0 : ~&vec2;
      2:       res_b2 = &vec2;
      3:       res_b2 = vec2[0] ? &vec2 : ~&vec2;
      default: res_b2 = ~&vec2;
    endcase
    res_a3 = ~&vec3;
    res_b3 = ~&vec3;
  end

  // Instance-selected views of the outputs.
  int sel;
  logic [7:0] m_vec, m_ff;
  logic [8:0] m_err;
  logic       m_busy, m_done, m_pass, m_fv;
  always_comb begin
    if (sel == 0) begin
      m_vec = {6'd0, vec2}; m_ff = {6'd0, ff2}; m_err = {6'd0, err2};
      m_busy = busy2; m_done = done2; m_pass = pass2; m_fv = fv2;
    end else begin
      m_vec = {5'd0, vec3}; m_ff = {5'd0, ff3}; m_err = {5'd0, err3};
      m_busy = busy3; m_done = done3; m_pass = pass3; m_fv = fv3;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input int s, input logic v);
    if (s == 0) start2 = v;
    else        start3 = v;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec2"}, int'(vec2), 0);
    chk({tag, "_busy2"}, int'(busy2), 0);
    chk({tag, "_done2"}, int'(done2), 0);
    chk({tag, "_pass2"}, int'(pass2), 0);
    chk({tag, "_err2"}, int'(err2), 0);
    chk({tag, "_fv2"}, int'(fv2), 0);
    chk({tag, "_ff2"}, int'(ff2), 0);
  endtask

  // Issue a start, then follow the sweep to DONE. Optionally pulse start
  // again at edge poke_at (must be ignored) or stop early at vec == stop_vec.
  task automatic run_sweep(input int s, input int n, input int settle,
                           input int poke_at, input int stop_vec,
                           output bit stopped);
    int edges;
    stopped = 0;
    exp_q.delete();
    @(negedge clk);
    drive_start(s, 1'b1);
    for (int v = 0; v < (1 << n); v++)
      for (int k = 0; k <= settle; k++) exp_q.push_back(8'(v));
    @(negedge clk);
    drive_start(s, 1'b0);
    chk("clear_err", int'(m_err), 0);
    chk("clear_fv", int'(m_fv), 0);
    chk("clear_ff", int'(m_ff), 0);
    chk("start_busy", int'(m_busy), 1);
    chk("start_done", int'(m_done), 0);
    edges = 0;
    while (!m_done && edges < 200) begin
      if (exp_q.size() == 0) begin
        chk("vec_queue_underrun", exp_q.size(), 1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("vec_seq", int'(m_vec), int'(e));
      end
      if (stop_vec >= 0 && int'(m_vec) == stop_vec) begin
        stopped = 1;
        return;
      end
      @(negedge clk);
      drive_start(s, (edges + 1 == poke_at) ? 1'b1 : 1'b0);
      edges++;
    end
    drive_start(s, 1'b0);
    chk("done_edge", edges, (1 << n) * (settle + 1));
    chk("queue_drained", exp_q.size(), 0);
    chk("final_vec", int'(m_vec), (1 << n) - 1);
    chk("done_busy", int'(m_busy), 0);
  endtask

  // ---------------- table of sweeps ----------------
  typedef struct {
    int sel; int md; int poke;
    int exp_err; int exp_pass; int exp_fv; int exp_ff;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bit stopped;
    reset = 1'b1; start2 = 1'b0; start3 = 1'b0; mode = 0; sel = 0;

    tbl[0] = '{0, 0, -1, 0, 1, 0, 0};  // identical NAND pair
    tbl[1] = '{0, 1, -1, 1, 0, 1, 2};  // B stuck low at vec 10
    tbl[2] = '{0, 2, -1, 4, 0, 1, 0};  // B always inverted: full count
    tbl[3] = '{0, 3, -1, 2, 0, 1, 1};  // mismatches at 01 and 11
    tbl[4] = '{0, 0, -1, 0, 1, 0, 0};  // restart from DONE with err 2
    tbl[5] = '{1, 0, 10, 0, 1, 0, 0};  // N=3, SETTLE=3, ignored start

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    chk("reset_vec3", int'(vec3), 0);
    chk("reset_busy3", int'(busy3), 0);
    chk("reset_done3", int'(done3), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel  = tbl[i].sel;
      mode = tbl[i].md;
      if (sel == 0) run_sweep(0, 2, 1, tbl[i].poke, -1, stopped);
      else          run_sweep(1, 3, 3, tbl[i].poke, -1, stopped);
      chk($sformatf("t%0d_err", i), int'(m_err), tbl[i].exp_err);
      chk($sformatf("t%0d_pass", i), int'(m_pass), tbl[i].exp_pass);
      chk($sformatf("t%0d_fv", i), int'(m_fv), tbl[i].exp_fv);
      chk($sformatf("t%0d_ff", i), int'(m_ff), tbl[i].exp_ff);
      chk($sformatf("t%0d_done", i), int'(m_done), 1);
      repeat (2) @(negedge clk);
      chk($sformatf("t%0d_hold_err", i), int'(m_err), tbl[i].exp_err);
      chk($sformatf("t%0d_hold_done", i), int'(m_done), 1);
    end

    // Mid-sweep async reset at vec 01, with a nonzero error count pending.
    sel = 0; mode = 2;
    run_sweep(0, 2, 1, -1, 1, stopped);
    chk("reached_vec01", int'(stopped), 1);
    chk("pre_reset_err", int'(err2), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    run_sweep(0, 2, 1, -1, -1, stopped);
    chk("post_reset_err", int'(err2), 0);
    chk("post_reset_pass", int'(pass2), 1);
    chk("post_reset_fv", int'(fv2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
